// File: rtl/waveshaper_voice_scheduler.sv
// Time-multiplexes one shared waveshaper across NUM_VOICES voices per sample.
// Optional build macro WAVESHAPER_SCHED_SATURATE_EN: saturating sum mix.
module waveshaper_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 8 + $clog2(NUM_VOICES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic [NUM_VOICES-1:0]     voice_en,
  input  logic [2*NUM_VOICES-1:0]   voice_mode,
  input  logic [16*NUM_VOICES-1:0]  voice_step,
  output logic [7:0]                ws_quotient,
  output logic [1:0]                ws_mode,
  input  logic [7:0]                ws_sample,
  output logic [7:0]                mix_out,
  output logic                      mix_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IW = $clog2(NUM_VOICES);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]    idx;
  logic [ACC_W-1:0] acc;
  logic [15:0]      phase [NUM_VOICES];

  logic             cur_en;
  logic [1:0]       cur_mode;
  logic [15:0]      cur_step;
  logic             last;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] avg;
  logic [7:0]       mix_f;

  assign cur_en   = voice_en[idx];
  assign cur_mode = voice_mode[{idx, 1'b0} +: 2];
  assign cur_step = voice_step[{idx, 4'b0000} +: 16];
  assign last     = (idx == IW'(NUM_VOICES - 1));
  assign sum      = acc + ACC_W'(ws_sample);
  assign avg      = sum >> IW;
  assign busy     = (state == SCAN);

`ifdef WAVESHAPER_SCHED_SATURATE_EN
  assign mix_f = (sum > ACC_W'(255)) ? 8'hFF : sum[7:0];
`else
  assign mix_f = avg[7:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and waveshaper input decode
  always_comb begin
    state_nxt   = state;
    ws_quotient = 8'h00;
    ws_mode     = 2'b11;
    unique case (state)
      IDLE: begin
        if (sample_tick) state_nxt = SCAN;
      end
      SCAN: begin
        if (cur_en) begin
          ws_quotient = phase[idx][15:8];
          ws_mode     = cur_mode;
        end
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase, accumulator, mix and overrun datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      mix_out   <= 8'h00;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) phase[v] <= 16'h0000;
    end else begin
      mix_valid <= 1'b0;
      if (state == SCAN && sample_tick) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (sample_tick) begin
            idx <= '0;
            acc <= '0;
          end
        end
        SCAN: begin
          acc <= sum;
          if (cur_en) phase[idx] <= phase[idx] + cur_step;
          else        phase[idx] <= 16'h0000;
          if (last) begin
            mix_out   <= mix_f;
            mix_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/waveshaper_voice_scheduler.md
# waveshaper_voice_scheduler

Time-multiplexes the single shared waveshaper across `NUM_VOICES` voices. Once per audio sample period it walks every voice: it advances that voice's phase accumulator, presents the phase quotient and mode to the waveshaper, and collects the returned sample into a mix. It sits between the per-voice control registers (note steps, modes, enables) and the PWM/DAC output stage, and owns the waveshaper's inputs exclusively.

## Interface
Parameters:
- `NUM_VOICES`, default 4: number of voices. Must be a power of two, 2..16.
- `ACC_W`, default `8+$clog2(NUM_VOICES)`: width of the mix accumulator. Derived; do not override.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `sample_tick`  in  1  one-cycle pulse that starts a sample period.
- `voice_en`  in  NUM_VOICES  per-voice enable.
- `voice_mode`  in  2*NUM_VOICES  per-voice waveshape mode. Voice v uses bits [2v+1:2v]: 00 saw, 01 triangle, 10 square, 11 silent.
- `voice_step`  in  16*NUM_VOICES  per-voice phase increment. Voice v uses bits [16v+15:16v].
- `ws_quotient`  out  8  quotient input to the waveshaper.
- `ws_mode`  out  2  mode input to the waveshaper.
- `ws_sample`  in  8  waveshaper output. Combinational in the same cycle.
- `mix_out`  out  8  mixed sample, registered.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `busy`  out  1  high while a scan is in progress.
- `overrun`  out  1  sticky flag. Set when `sample_tick` arrives while `busy`. Cleared only by `rst`.

## Operation
- The FSM has two states: IDLE and SCAN.
- Registers: a 16-bit `phase[v]` per voice, an index `idx` of width `$clog2(NUM_VOICES)`, and accumulator `acc[ACC_W-1:0]`.
- IDLE:
  - `ws_quotient`=0 and `ws_mode`=2'b11.
  - On `sample_tick`: `idx`←0, `acc`←0, go to SCAN.
- SCAN, voice `idx`, one voice per cycle:
  - `voice_en[idx]`=1: `ws_quotient`=`phase[idx][15:8]`, `ws_mode`=`voice_mode[idx]`. At the clock edge, `acc`←`acc`+`ws_sample` and `phase[idx]`←`phase[idx]`+`voice_step[idx]`. The phase addition wraps modulo 2^16.
  - `voice_en[idx]`=0: `ws_quotient`=0, `ws_mode`=2'b11. At the clock edge, `acc`←`acc`+`ws_sample` (this is 0) and `phase[idx]`←0. A voice that is re-enabled therefore restarts at phase 0.
  - Voice controls are sampled during that voice's own slot only. They are not latched at the tick.
  - When `idx`==NUM_VOICES-1: `mix_out`←f(final sum), `mix_valid`←1, go to IDLE. Otherwise `idx`←`idx`+1.
- Mix function f: `mix_out` = (`acc` + last sample) >> `$clog2(NUM_VOICES)`. This is a truncating average.
- `busy` is 1 exactly when the state is SCAN.
- `sample_tick` while in SCAN, including on the final SCAN cycle: the tick is ignored and `overrun`←1. Any scan in progress continues unaffected.
- Reset values: state IDLE, all `phase` 0, `idx` 0, `acc` 0, `mix_out` 0, `mix_valid` 0, `busy` 0, `overrun` 0.
- `rst` asserted mid-scan: the scan is aborted, no `mix_valid` is produced, and `mix_out` is cleared to 0.

## Timing
- Tick sampled at edge E0 → SCAN during cycles 1..N after E0.
- `mix_out`/`mix_valid` are registered at edge EN and are high during cycle N+1. Tick-to-valid latency is N+1 cycles.
- `mix_valid` is high for exactly one cycle. `mix_out` holds until the next update.
- Earliest accepted next tick: the cycle in which `mix_valid` is high, when the state is IDLE. Minimum tick period is therefore N+1 cycles.
- Waveshaper path: `ws_quotient`/`ws_mode` are decoded combinationally from state/`idx`. `ws_sample` is consumed in the same cycle. There is no extra pipeline stage.

## Configuration
- `WAVESHAPER_SCHED_SATURATE_EN`:
  - Defined: f = min(final sum, 255). This gives a saturating sum, so louder voices clip.
  - Undefined: f = truncating average, as above.
- Everything else is identical in both builds: latency, FSM, and `overrun`.

## Test plan
All scenarios use `NUM_VOICES`=4 unless stated otherwise.
- **Reset:** hold `rst` for 2 cycles → every output 0, `ws_mode`=2'b11. Assert `rst` in the 2nd SCAN cycle → next cycle `busy`=0, no `mix_valid`, all phases 0.
- **Single saw voice:** only voice0 enabled, mode 00, step 16'h4000. Four ticks spaced 8 cycles apart → voice0 slot `ws_quotient` = 0x00, 0x40, 0x80, 0xC0. Averaged `mix_out` = 0x00, 0x10, 0x20, 0x30, each with `mix_valid` exactly 5 cycles after its tick.
- **Square full mix:** all voices enabled, mode 10, step 16'h8000. First tick → `mix_out`=0. Second tick → all samples 255, sum 1020 → `mix_out`=255 in both builds.
- **Mixed levels:** voice0 square with phase ≥ 0x8000 (sample 255), voice1 saw with quotient 0x40 (sample 64), others disabled → `mix_out`=79 averaged, 255 with `WAVESHAPER_SCHED_SATURATE_EN`.
- **Overrun:** second tick 2 cycles after the first → `overrun`=1 and stays 1, only one `mix_valid`, phases advanced once.
- **Wrap and disable:** voice0 step 16'hC000 → quotients 0x00, 0xC0, 0x80 (wrapped). Deassert `voice_en[0]` for one scan, then reassert → quotient restarts at 0x00.
